axis_i2c_wr_master: RTL and testbench

//   AXI-Stream to I2C write engine; downstream consumer of the AXIS data FIFO in the I2C top.

---
 rtl/axis_i2c_wr_master.sv | 145 ++++++++++++++
 tb/tb_axis_i2c_wr_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2c_wr_master.sv
// AXIS word -> I2C register write: START, addr+W, reg, data, STOP.
// Define I2C_NACK_RETRY_EN to re-issue a NACKed word up to MAX_RETRY times.
module axis_i2c_wr_master #(
  parameter int unsigned CLK_DIV    = 250,
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [15:0] s_axis_tdata,
  output logic        scl_o,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        busy,
  output logic        nack_err
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP
  } state_t;

  state_t state, state_nx;

  logic [QW-1:0] qcnt;
  logic [1:0]    qtr;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic [15:0]   word;
  logic          nack;
  logic          retry;
  logic          q_end, slot_end;
  logic          bit_slot, ack_slot;

  assign q_end    = (qcnt == QMAX);
  assign slot_end = q_end && (qtr == 2'd3);
  assign bit_slot = state inside {ADDR, REG, DATA};
  assign ack_slot = state inside {ACK1, ACK2, ACK3};

  assign s_axis_tready = (state == IDLE);
  assign busy          = (state != IDLE);

`ifdef I2C_NACK_RETRY_EN
  logic [2:0] retry_cnt;

  assign retry = nack && (retry_cnt < 3'(MAX_RETRY));

  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      retry_cnt <= '0;
    else if (state == IDLE)
      retry_cnt <= '0;
    else if (state == STOP && slot_end && retry)
      retry_cnt <= retry_cnt + 3'd1;
  end
`else
  assign retry = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (s_axis_tvalid) state_nx = START;
      START: if (slot_end) state_nx = ADDR;
      ADDR:  if (slot_end && bitcnt == 3'd7) state_nx = ACK1;
      ACK1:  if (slot_end) state_nx = nack ? STOP : REG;
      REG:   if (slot_end && bitcnt == 3'd7) state_nx = ACK2;
      ACK2:  if (slot_end) state_nx = nack ? STOP : DATA;
      DATA:  if (slot_end && bitcnt == 3'd7) state_nx = ACK3;
      ACK3:  if (slot_end) state_nx = STOP;
      STOP:  if (slot_end) state_nx = retry ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      qcnt     <= '0;
      qtr      <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      word     <= '0;
      nack     <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      nack_err <= 1'b0;
      if (state == IDLE) begin
        qcnt   <= '0;
        qtr    <= '0;
        bitcnt <= '0;
        nack   <= 1'b0;
        if (s_axis_tvalid) word <= s_axis_tdata;
      end else begin
        qcnt <= q_end ? '0 : qcnt + 1'b1;
        if (q_end) qtr <= qtr + 2'd1;
        // ACK sampled at the end of the SCL high phase
        if (ack_slot && q_end && qtr == 2'd2) nack <= sda_i;
        if (slot_end) begin
          unique case (1'b1)
            state == START: shreg <= {SLAVE_ADDR, 1'b0};
            bit_slot: begin
              shreg  <= {shreg[6:0], 1'b0};
              bitcnt <= bitcnt + 3'd1;
            end
            state == ACK1: shreg <= word[15:8];
            state == ACK2: shreg <= word[7:0];
            state == STOP: begin
              nack     <= 1'b0;
              nack_err <= nack & ~retry;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    scl_o  = 1'b1;
    sda_oe = 1'b0;
    unique case (1'b1)
      state == START: sda_oe = qtr[1];
      bit_slot: begin
        scl_o  = qtr[0] ^ qtr[1];
        sda_oe = ~shreg[7];
      end
      ack_slot: scl_o = qtr[0] ^ qtr[1];
      state == STOP: begin
        scl_o  = (qtr != 2'd0);
        sda_oe = ~qtr[1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axis_i2c_wr_master.sv
// Bench for axis_i2c_wr_master: bus decoder + I2C slave model + word model.
// Retry expectations follow I2C_NACK_RETRY_EN when it is defined.
module tb_axis_i2c_wr_master;

  localparam int CD = 4;
  localparam logic [6:0] SA = 7'h3C;
  localparam int MR = 3;
  localparam int BUDGET = 4 * CD * 29 * (MR + 1) + 64;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [15:0] s_axis_tdata = '0;
  logic        scl_o, sda_oe, busy, nack_err;
  logic        sda_i = 1'b1;

  axis_i2c_wr_master #(
    .CLK_DIV(CD), .SLAVE_ADDR(SA), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .arst(arst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i),
    .busy(busy), .nack_err(nack_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // bus decoder and slave state
  logic prev_scl = 1'b1, prev_line = 1'b1;
  logic pull = 1'b0, have_rise = 1'b0, bit_hi = 1'b0, in_frame = 1'b0;
  int bitn = 0, attempt = 0, n_start = 0, n_stop = 0, stray = 0;
  int cfg_at = 0, cfg_tries = 0;
  logic [31:0] cur_v = '0;
  logic [31:0] got_v[$], exp_v[$];
  int got_n[$], exp_n[$];

  function automatic logic slave_nack(input int k);
    return (attempt <= cfg_tries) && (k == cfg_at);
  endfunction

  task automatic mon();
    logic line;
    line = ~(sda_oe | pull);
    if (!prev_scl && scl_o && line !== prev_line) stray++;
    if (prev_scl && scl_o && prev_line && !line) begin
      n_start++;
      attempt++;
      in_frame = 1'b1;
      bitn = 0;
      cur_v = '0;
      have_rise = 1'b0;
    end else if (prev_scl && scl_o && !prev_line && line) begin
      n_stop++;
      if (in_frame) begin
        got_v.push_back(cur_v);
        got_n.push_back(bitn);
      end
      in_frame = 1'b0;
      have_rise = 1'b0;
      pull = 1'b0;
    end else if (!prev_scl && scl_o) begin
      have_rise = 1'b1;
      bit_hi = line;
    end else if (prev_scl && !scl_o) begin
      if (have_rise && in_frame) begin
        cur_v = {cur_v[30:0], bit_hi};
        bitn++;
      end else if (have_rise) begin
        stray++;
      end
      have_rise = 1'b0;
      pull = in_frame && (bitn % 9 == 8) && !slave_nack(bitn / 9 + 1);
    end
    prev_scl = scl_o;
    prev_line = ~(sda_oe | pull);
    sda_i = prev_line;
  endtask

  task automatic mon_clear();
    pull = 1'b0;
    in_frame = 1'b0;
    have_rise = 1'b0;
    bitn = 0;
    prev_scl = scl_o;
    prev_line = ~sda_oe;
    sda_i = prev_line;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  // expected bus frames, latency and error pulse for one word
  task automatic model(input logic [15:0] d, input int at, input int tries,
                       output int lat, output int err, output int att);
    logic [7:0] by[3];
    int maxatt;
    logic nk;
    int nb;
    logic [31:0] v;
    by[0] = {SA, 1'b0};
    by[1] = d[15:8];
    by[2] = d[7:0];
`ifdef I2C_NACK_RETRY_EN
    maxatt = MR + 1;
`else
    maxatt = 1;
`endif
    lat = 0;
    err = 0;
    att = 0;
    for (int a = 1; a <= maxatt; a++) begin
      nk = (a <= tries);
      nb = nk ? at : 3;
      v = '0;
      for (int b = 0; b < nb; b++)
        v = (v << 9) | 32'({by[b], nk && (b == nb - 1)});
      exp_v.push_back(v);
      exp_n.push_back(9 * nb);
      lat += 4 * CD * (nk ? 2 + 9 * at : 29);
      att++;
      if (!nk) break;
      if (a == maxatt) err = 1;
    end
  endtask

  task automatic check_trans(input string tag);
    check({tag, " ntrans"}, got_v.size(), exp_v.size());
    for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) begin
      check({tag, " bits"}, got_v[i], exp_v[i]);
      check({tag, " nbits"}, got_n[i], exp_n[i]);
    end
  endtask

  task automatic start_word(input int at, input int tries);
    exp_v.delete();
    exp_n.delete();
    got_v.delete();
    got_n.delete();
    cfg_at = at;
    cfg_tries = tries;
    attempt = 0;
    n_start = 0;
    n_stop = 0;
    stray = 0;
  endtask

  task automatic do_word(input logic [15:0] d, input int at, input int tries,
                         input string tag, output int lat, output int errs);
    int elat, eerr, eatt, busy_n;
    start_word(at, tries);
    model(d, at, tries, elat, eerr, eatt);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    tick();
    check({tag, " accept"}, s_axis_tready, 0);
    lat = 1;
    busy_n = busy;
    errs = nack_err;
    while (lat < BUDGET) begin
      s_axis_tvalid = 1'($urandom);
      s_axis_tdata = 16'($urandom);
      tick();
      errs += nack_err;
      if (s_axis_tready) break;
      lat++;
      busy_n += busy;
    end
    s_axis_tvalid = 1'b0;
    check({tag, " idle busy"}, busy, 0);
    tick();
    errs += nack_err;
    check({tag, " latency"}, lat, elat);
    check({tag, " busy span"}, busy_n, elat);
    check({tag, " nack_err"}, errs, eerr);
    check({tag, " starts"}, n_start, eatt);
    check({tag, " stops"}, n_stop, eatt);
    check({tag, " protocol"}, stray, 0);
    check_trans(tag);
  endtask

  typedef struct {
    logic [15:0] d;
    int at;
    int tries;
    int lat_nr;
    int err_nr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, errs, n, elat, eerr, eatt;

    tbl[0] = '{16'hA55A, 1, 0, 464, 0};
    tbl[1] = '{16'hA55A, 1, 1, 176, 1};
    tbl[2] = '{16'h1234, 2, 1, 320, 1};
    tbl[3] = '{16'hFFFF, 3, 1, 464, 1};
    tbl[4] = '{16'h0000, 2, 0, 464, 0};
    tbl[5] = '{16'h80FE, 2, 9, 320, 1};
    tbl[6] = '{16'h5A00, 3, 2, 464, 1};

    repeat (2) @(negedge clk);
    check("rst tready", s_axis_tready, 1);
    check("rst scl", scl_o, 1);
    check("rst sda_oe", sda_oe, 0);
    check("rst busy", busy, 0);
    check("rst nack_err", nack_err, 0);
    arst = 1'b0;
    mon_clear();
    tick();

    do_word(16'hA55A, 1, 0, "t1", lat, errs);
    check("t1 lat 464", lat, 464);
    check("t1 bytes", got_v.size() > 0 ? got_v[0] : 32'hx, 32'h3C294B4);
    check("t1 nack_err", errs, 0);

    do_word(16'hA55A, 1, 1, "t2", lat, errs);
`ifndef I2C_NACK_RETRY_EN
    check("t2 lat", lat, 176);
    check("t2 addr only", got_v.size() > 0 ? got_v[0] : 32'hx, 32'h0F1);
    check("t2 nack_err", errs, 1);
`endif

    for (int i = 0; i < 7; i++) begin
      do_word(tbl[i].d, tbl[i].at, tbl[i].tries, "tbl", lat, errs);
`ifndef I2C_NACK_RETRY_EN
      check("tbl lat", lat, tbl[i].lat_nr);
      check("tbl err", errs, tbl[i].err_nr);
`endif
    end

    for (int i = 0; i < 12; i++) begin
      int tr;
`ifdef I2C_NACK_RETRY_EN
      tr = $urandom_range(0, 5);
`else
      tr = $urandom_range(0, 1);
`endif
      do_word(16'($urandom), $urandom_range(1, 3), tr, "rand", lat, errs);
    end

    // back-to-back words with tvalid held high
    start_word(1, 0);
    model(16'h0102, 1, 0, elat, eerr, eatt);
    model(16'h0304, 1, 0, elat, eerr, eatt);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'h0102;
    tick();
    check("b2b accept1", s_axis_tready, 0);
    n = 1;
    while (n < BUDGET) begin
      s_axis_tdata = 16'($urandom);
      tick();
      if (s_axis_tready) break;
      n++;
    end
    check("b2b lat1", n, 464);
    s_axis_tdata = 16'h0304;
    tick();
    check("b2b gap", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;
    n = 1;
    while (n < BUDGET) begin
      s_axis_tdata = 16'($urandom);
      tick();
      if (s_axis_tready) break;
      n++;
    end
    check("b2b lat2", n, 464);
    tick();
    check("b2b starts", n_start, 2);
    check("b2b protocol", stray, 0);
    check_trans("b2b");

    // async reset in the middle of the REG byte
    start_word(1, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'h0F33;
    tick();
    s_axis_tvalid = 1'b0;
    repeat (173) tick();
    check("arst pre scl", scl_o, 0);
    check("arst pre sda_oe", sda_oe, 1);
    arst = 1'b1;
    #1;
    check("arst scl", scl_o, 1);
    check("arst sda_oe", sda_oe, 0);
    check("arst busy", busy, 0);
    check("arst tready", s_axis_tready, 1);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    mon_clear();
    tick();
    do_word(16'hBEEF, 1, 0, "post-arst", lat, errs);

`ifdef I2C_NACK_RETRY_EN
    do_word(16'h1234, 1, 99, "t5 all", lat, errs);
    check("t5 all starts", n_start, 4);
    check("t5 all err", errs, 1);
    do_word(16'h1234, 1, 1, "t5 once", lat, errs);
    check("t5 once starts", n_start, 2);
    check("t5 once err", errs, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
